mem_bank_responder: RTL and testbench

- Responder end of the internal memory request bus (request/write/bank/address/data in; busy/ack/data out) that save-emulation controllers use as initiators.
- Backs one bank ID with on-chip block RAM.
- Has configurable read latency and configurable back-pressure, so it can stand in for the SDRAM bank during save-controller bring-up and verification.
- Sits on the memory bus in parallel with other bank responders; upstream OR-combines its busy/ack outputs with theirs.

---
 rtl/mem_bank_responder.sv | 119 +++++++++++
 tb/tb_mem_bank_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_bank_responder.sv
// Memory-bus bank responder: serves one bank ID from on-chip RAM, stands in for an SDRAM bank.
// Latency: a read acks exactly READ_LATENCY (2..8) cycles after its accept edge; writes commit on accept and never ack.
// Backpressure: registered o_mem_busy stays high ACCEPT_GAP cycles after each accept; busy requests are simply not taken.
//
// Ports:
//   i_clk, i_reset                : clock, synchronous active-high reset
//   i_mem_request / i_mem_write   : request valid (held until accepted), 1 = write / 0 = read
//   i_mem_bank / i_mem_address    : target bank, word address (low ADDR_BITS used, upper bits alias)
//   i_mem_data                    : write data
//   o_mem_busy                    : back-pressure, registered, not bank-qualified
//   o_mem_ack / o_mem_data        : one-cycle read-data-valid pulse, read data (held between acks)
module mem_bank_responder #(
  parameter logic [3:0]  BANK         = 4'd1,
  parameter int          ADDR_BITS    = 10,
  parameter int          READ_LATENCY = 2,
  parameter int          ACCEPT_GAP   = 0,
  parameter logic [31:0] INIT_VALUE   = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_request,
  input  logic        i_mem_write,
  input  logic [3:0]  i_mem_bank,
  input  logic [23:0] i_mem_address,
  input  logic [31:0] i_mem_data,
  output logic        o_mem_busy,
  output logic        o_mem_ack,
  output logic [31:0] o_mem_data
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = (ACCEPT_GAP > 0) ? $clog2(ACCEPT_GAP + 1) : 1;

  // Words are stored XOR-ed with INIT_VALUE: RAM configures to all-zero,
  // so a never-written word reads back as INIT_VALUE without a valid bitmap.
  logic [31:0]           mem_q [DEPTH];
  logic [ADDR_BITS-1:0]  idx;
  logic                  accept;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  busy_q;
  logic [READ_LATENCY-1:0] vld_q;
  logic [31:0]           dat_q [READ_LATENCY];
  logic                  ack_q;
  logic [31:0]           rdat_q;

  assign idx    = i_mem_address[ADDR_BITS-1:0];
  assign accept = i_mem_request && !busy_q && (i_mem_bank == BANK);

  generate
    if (ADDR_BITS < 24) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^i_mem_address[23:ADDR_BITS];
    end
  endgenerate

  // Reload on accept wins over the decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = CW'(ACCEPT_GAP);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // busy_q mirrors (cnt_q != 0) but is forced high through the reset cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  // Write commits on the accept edge; a write presented in a reset cycle is dropped.
  // RAM is never reset so contents survive i_reset.
  always_ff @(posedge i_clk) begin
    if (accept && i_mem_write && !i_reset) begin
      mem_q[idx] <= i_mem_data ^ INIT_VALUE;
    end
  end

  // Read data is captured on the accept edge, so it sees every earlier write
  // and is immune to writes accepted later. Stage j holds data j cycles past accept.
  always_ff @(posedge i_clk) begin
    dat_q[0] <= mem_q[idx] ^ INIT_VALUE;
    for (int j = 1; j < READ_LATENCY; j++) begin
      dat_q[j] <= dat_q[j-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[READ_LATENCY-2:0], accept && !i_mem_write};
    end
  end

  // Output register adds the final cycle: ack lands READ_LATENCY edges after accept.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q <= vld_q[READ_LATENCY-1];
      if (vld_q[READ_LATENCY-1]) begin
        rdat_q <= dat_q[READ_LATENCY-1];
      end
    end
  end

  assign o_mem_busy = busy_q;
  assign o_mem_ack  = ack_q;
  assign o_mem_data = rdat_q;

endmodule

// File: tb/tb_mem_bank_responder.sv
// Directed bench for mem_bank_responder over three configurations:
//   u0: READ_LATENCY=2, ACCEPT_GAP=0   u1: READ_LATENCY=2, ACCEPT_GAP=2   u2: READ_LATENCY=4, ACCEPT_GAP=0
module tb_mem_bank_responder;

  logic        clk;
  logic        rst   [3];
  logic        req   [3];
  logic        wr    [3];
  logic [3:0]  bank  [3];
  logic [23:0] addr  [3];
  logic [31:0] wdat  [3];
  logic        busy  [3];
  logic        ack   [3];
  logic [31:0] rdat  [3];

  int n_checks;
  int n_fail;

  mem_bank_responder #(.BANK(4'd1), .ADDR_BITS(10), .READ_LATENCY(2), .ACCEPT_GAP(0),
                       .INIT_VALUE(32'hFFFF_FFFF)) u0 (
    .i_clk(clk), .i_reset(rst[0]), .i_mem_request(req[0]), .i_mem_write(wr[0]),
    .i_mem_bank(bank[0]), .i_mem_address(addr[0]), .i_mem_data(wdat[0]),
    .o_mem_busy(busy[0]), .o_mem_ack(ack[0]), .o_mem_data(rdat[0]));

  mem_bank_responder #(.BANK(4'd1), .ADDR_BITS(10), .READ_LATENCY(2), .ACCEPT_GAP(2),
                       .INIT_VALUE(32'hFFFF_FFFF)) u1 (
    .i_clk(clk), .i_reset(rst[1]), .i_mem_request(req[1]), .i_mem_write(wr[1]),
    .i_mem_bank(bank[1]), .i_mem_address(addr[1]), .i_mem_data(wdat[1]),
    .o_mem_busy(busy[1]), .o_mem_ack(ack[1]), .o_mem_data(rdat[1]));

  mem_bank_responder #(.BANK(4'd1), .ADDR_BITS(10), .READ_LATENCY(4), .ACCEPT_GAP(0),
                       .INIT_VALUE(32'hFFFF_FFFF)) u2 (
    .i_clk(clk), .i_reset(rst[2]), .i_mem_request(req[2]), .i_mem_write(wr[2]),
    .i_mem_bank(bank[2]), .i_mem_address(addr[2]), .i_mem_data(wdat[2]),
    .o_mem_busy(busy[2]), .o_mem_ack(ack[2]), .o_mem_data(rdat[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int i, input logic [23:0] a);
    req[i] = 1'b1; wr[i] = 1'b0; bank[i] = 4'd1; addr[i] = a; wdat[i] = '0;
  endtask

  task automatic wrt(input int i, input logic [23:0] a, input logic [31:0] d);
    req[i] = 1'b1; wr[i] = 1'b1; bank[i] = 4'd1; addr[i] = a; wdat[i] = d;
  endtask

  task automatic idle(input int i);
    req[i] = 1'b0; wr[i] = 1'b0;
  endtask

  task automatic chk_ack(input int i, input string tag, input logic exp_ack, input logic [31:0] exp_dat);
    chk({tag, "_ack"}, {31'd0, ack[i]}, {31'd0, exp_ack});
    if (exp_ack) chk({tag, "_dat"}, rdat[i], exp_dat);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; wr[i] = 1'b0;
      bank[i] = 4'd1; addr[i] = '0; wdat[i] = '0;
    end

    // ---------------- reset state (all instances) ----------------
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", {31'd0, busy[i]}, 32'd1);
      chk("rst_ack",  {31'd0, ack[i]},  32'd0);
      chk("rst_data", rdat[i], 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0; rst[2] = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) chk("post_rst_busy", {31'd0, busy[i]}, 32'd0);

    // ---------------- u0: back-to-back reads of erased words 0..3 ----------------
    rd(0, 24'd0); tick(); chk_ack(0, "rd4_e1", 1'b0, '0);
    rd(0, 24'd1); tick(); chk_ack(0, "rd4_e2", 1'b0, '0);
    rd(0, 24'd2); tick(); chk_ack(0, "rd4_a0", 1'b1, 32'hFFFF_FFFF);
    rd(0, 24'd3); tick(); chk_ack(0, "rd4_a1", 1'b1, 32'hFFFF_FFFF);
    idle(0);      tick(); chk_ack(0, "rd4_a2", 1'b1, 32'hFFFF_FFFF);
                  tick(); chk_ack(0, "rd4_a3", 1'b1, 32'hFFFF_FFFF);
                  tick(); chk_ack(0, "rd4_end", 1'b0, '0);

    // ---------------- u0: write then read-back next cycle ----------------
    wrt(0, 24'd5, 32'h1234_5678); tick(); chk_ack(0, "wr5_noack", 1'b0, '0);
    rd(0, 24'd5);                 tick(); chk_ack(0, "rb5_e1", 1'b0, '0);
    idle(0);                      tick(); chk_ack(0, "rb5_e2", 1'b0, '0);
                                  tick(); chk_ack(0, "rb5", 1'b1, 32'h1234_5678);
                                  tick(); chk_ack(0, "rb5_single", 1'b0, '0);
    chk("rb5_hold", rdat[0], 32'h1234_5678);

    // ---------------- u0: address wrap modulo depth ----------------
    wrt(0, 24'h000400, 32'hA5A5_A5A5); tick();
    rd(0, 24'h000000);                 tick();
    idle(0);                           tick(); chk_ack(0, "wrap_e", 1'b0, '0);
                                       tick(); chk_ack(0, "wrap", 1'b1, 32'hA5A5_A5A5);

    // ---------------- u0: foreign bank ignored ----------------
    req[0] = 1'b1; wr[0] = 1'b0; bank[0] = 4'd2; addr[0] = 24'd5;
    tick(); chk_ack(0, "bank_e1", 1'b0, '0);
    tick(); chk_ack(0, "bank_e2", 1'b0, '0);
    idle(0);
    tick(); chk_ack(0, "bank_e3", 1'b0, '0);
    tick(); chk_ack(0, "bank_e4", 1'b0, '0);

    // ---------------- u0: read then immediate write to same word ----------------
    rd(0, 24'd7);            tick();
    wrt(0, 24'd7, 32'h0);    tick(); chk_ack(0, "ord_e", 1'b0, '0);
    idle(0);                 tick(); chk_ack(0, "ord_old", 1'b1, 32'hFFFF_FFFF);
    rd(0, 24'd7);            tick(); chk_ack(0, "ord_gap", 1'b0, '0);
    idle(0);                 tick(); chk_ack(0, "ord_gap2", 1'b0, '0);
                             tick(); chk_ack(0, "ord_new", 1'b1, 32'h0);

    // ---------------- u1: ACCEPT_GAP=2 back-pressure ----------------
    wrt(1, 24'd10, 32'h1111_000A); tick(); chk("gap_w0_b0", {31'd0, busy[1]}, 32'd1);
    idle(1);                       tick(); chk("gap_w0_b1", {31'd0, busy[1]}, 32'd1);
                                   tick(); chk("gap_w0_b2", {31'd0, busy[1]}, 32'd0);
    wrt(1, 24'd11, 32'h2222_000B); tick();
    idle(1);                       tick(); tick();
    wrt(1, 24'd12, 32'h3333_000C); tick();
    idle(1);                       tick(); tick();
    chk("gap_idle_busy", {31'd0, busy[1]}, 32'd0);

    // Request held high; address advanced only after each expected accept.
    rd(1, 24'd10);  tick(); chk("gap_r0_busy", {31'd0, busy[1]}, 32'd1); chk_ack(1, "gap_r0", 1'b0, '0);
    rd(1, 24'd11);  tick(); chk("gap_r0p1_busy", {31'd0, busy[1]}, 32'd1); chk_ack(1, "gap_r0p1", 1'b0, '0);
                    tick(); chk("gap_r0p2_busy", {31'd0, busy[1]}, 32'd0); chk_ack(1, "gap_a0", 1'b1, 32'h1111_000A);
                    tick(); chk("gap_r1_busy", {31'd0, busy[1]}, 32'd1); chk_ack(1, "gap_r1", 1'b0, '0);
    rd(1, 24'd12);  tick(); chk_ack(1, "gap_r1p1", 1'b0, '0);
                    tick(); chk("gap_r1p2_busy", {31'd0, busy[1]}, 32'd0); chk_ack(1, "gap_a1", 1'b1, 32'h2222_000B);
                    tick(); chk("gap_r2_busy", {31'd0, busy[1]}, 32'd1); chk_ack(1, "gap_r2", 1'b0, '0);
    idle(1);        tick(); chk_ack(1, "gap_r2p1", 1'b0, '0);
                    tick(); chk_ack(1, "gap_a2", 1'b1, 32'h3333_000C);
                    tick(); chk_ack(1, "gap_end", 1'b0, '0);

    // ---------------- u2: reset mid-flight, RL=4 ----------------
    wrt(2, 24'd3, 32'hCAFE_BABE); tick();
    rd(2, 24'd1);                 tick();
    rd(2, 24'd2);                 tick();
    // Reset cycle also presents a write that must be dropped.
    wrt(2, 24'd3, 32'hDEAD_BEEF); rst[2] = 1'b1; tick();
    chk("mid_rst_busy", {31'd0, busy[2]}, 32'd1);
    chk_ack(2, "mid_rst", 1'b0, '0);
    idle(2); rst[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_ack(2, "flush", 1'b0, '0);
    end
    chk("flush_busy", {31'd0, busy[2]}, 32'd0);
    chk("flush_data", rdat[2], 32'd0);
    rd(2, 24'd3); tick();
    idle(2);      tick(); chk_ack(2, "ret_e1", 1'b0, '0);
                  tick(); chk_ack(2, "ret_e2", 1'b0, '0);
                  tick(); chk_ack(2, "ret_e3", 1'b0, '0);
                  tick(); chk_ack(2, "retained", 1'b1, 32'hCAFE_BABE);
                  tick(); chk_ack(2, "ret_end", 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
